// File: rtl/call_return_ctrl.sv
// Call/return sequencer sitting in front of the return stack: converts decoder CALL/RET
// requests into push/pop commands plus a PC redirect, tracks stack depth, latches faults.
module call_return_ctrl #(
  parameter int unsigned STACK_SIZE = 64,
  parameter int unsigned DEPTH_W    = 7
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               call,
  input  logic               ret,
  input  logic [15:0]        pc,
  input  logic [15:0]        target,
  input  logic [15:0]        a,
  output logic [1:0]         stackOP,
  output logic [15:0]        w,
  output logic [15:0]        pc_next,
  output logic               pc_load,
  output logic               busy,
  output logic [DEPTH_W-1:0] depth,
  output logic               fault,
  output logic [1:0]         fault_code
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [1:0] OP_HOLD = 2'd0;
  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd3;

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_OVER  = 2'd1;
  localparam logic [1:0] FC_UNDER = 2'd2;
  localparam logic [1:0] FC_BOTH  = 2'd3;

  localparam logic [DEPTH_W-1:0] MAX_DEPTH = DEPTH_W'(STACK_SIZE);

  state_t             state_q, state_d;
  logic [1:0]         stack_op_q, stack_op_d;
  logic [15:0]        w_q, w_d;
  logic [15:0]        pc_next_q, pc_next_d;
  logic               pc_load_q, pc_load_d;
  logic               busy_q, busy_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               fault_q, fault_d;
  logic [1:0]         fault_code_q, fault_code_d;

  always_comb begin
    state_d      = state_q;
    stack_op_d   = OP_HOLD;
    w_d          = w_q;
    pc_next_d    = pc_next_q;
    pc_load_d    = 1'b0;
    busy_d       = busy_q;
    depth_d      = depth_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        // Conflict is checked before capacity so call&ret always reports code 3.
        if (call && ret) begin
          state_d      = FAULT;
          fault_d      = 1'b1;
          fault_code_d = FC_BOTH;
          busy_d       = 1'b1;
        end else if (call) begin
          if (depth_q >= MAX_DEPTH) begin
            state_d      = FAULT;
            fault_d      = 1'b1;
            fault_code_d = FC_OVER;
            busy_d       = 1'b1;
          end else begin
            state_d    = EXEC;
            stack_op_d = OP_PUSH;
            w_d        = pc + 16'd1;
            pc_next_d  = target;
            pc_load_d  = 1'b1;
            busy_d     = 1'b1;
            depth_d    = depth_q + 1'b1;
          end
        end else if (ret) begin
          if (depth_q == '0) begin
            state_d      = FAULT;
            fault_d      = 1'b1;
            fault_code_d = FC_UNDER;
            busy_d       = 1'b1;
          end else begin
            state_d    = EXEC;
            stack_op_d = OP_POP;
            pc_next_d  = a;
            pc_load_d  = 1'b1;
            busy_d     = 1'b1;
            depth_d    = depth_q - 1'b1;
          end
        end
      end
      EXEC: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      FAULT: begin
        busy_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      stack_op_q   <= OP_HOLD;
      w_q          <= '0;
      pc_next_q    <= '0;
      pc_load_q    <= 1'b0;
      busy_q       <= 1'b0;
      depth_q      <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_d;
      stack_op_q   <= stack_op_d;
      w_q          <= w_d;
      pc_next_q    <= pc_next_d;
      pc_load_q    <= pc_load_d;
      busy_q       <= busy_d;
      depth_q      <= depth_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign stackOP    = stack_op_q;
  assign w          = w_q;
  assign pc_next    = pc_next_q;
  assign pc_load    = pc_load_q;
  assign busy       = busy_q;
  assign depth      = depth_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule
